// File: rtl/clock_monitor_pkg.sv
// Shared constants and FSM encoding for the clock monitor.
// Optional stuck-input detection is enabled by defining CLOCK_MONITOR_STUCK_EN.
package clock_monitor_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_EXP_HALF = 5;
    localparam int DEF_TOL      = 1;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        SKIP  = 2'd1,
`ifdef CLOCK_MONITOR_STUCK_EN
        RUN   = 2'd2,
        STUCK = 2'd3
`else
        RUN   = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/clock_monitor_sync_edge_det.sv
// Two-flop synchronizer for the monitored clock plus a registered copy for edge detection.
// Not affected by CLOCK_MONITOR_STUCK_EN.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta, mon_s, mon_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            mon_s <= 1'b0;
            mon_d <= 1'b0;
        end else begin
            meta  <= din;
            mon_s <= meta;
            mon_d <= mon_s;
        end
    end

    assign level = mon_s;
    assign rise  = mon_s & ~mon_d;
    assign fall  = ~mon_s & mon_d;

endmodule

// File: rtl/clock_monitor.sv
// Measures high/low phase lengths of an asynchronous clock and flags out-of-tolerance phases.
// Define CLOCK_MONITOR_STUCK_EN to add the STUCK state and the stuck output.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HALF = DEF_EXP_HALF,
    parameter int TOL      = DEF_TOL,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mon_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] hi_len,
    output logic [CNT_W-1:0] lo_len,
    output logic [CNT_W:0]   period,
    output logic             period_valid,
    output logic             err,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CMAX   = '1;
    localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(EXP_HALF + TOL);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             level, rise, fall, edge_det, capture, bad, have_hi;

    sync_edge_det u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mon_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_det = rise | fall;
    // The phase ending at an ACQ edge started before reset and is never trusted.
    assign capture  = edge_det && (state == SKIP || state == RUN);
    assign bad      = (cnt == CMAX) || (cnt < LO_LIM) || (cnt > HI_LIM);

`ifdef CLOCK_MONITOR_STUCK_EN
    localparam bit               TO_OK  = TIMEOUT < 2**CNT_W;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    logic to_hit;
    assign to_hit = TO_OK && (cnt >= TO_LIM);
    assign stuck  = (state == STUCK);
`else
    assign stuck  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACQ;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACQ:     if (edge_det) state_nxt = SKIP;
            SKIP:    if (edge_det) state_nxt = RUN;
            RUN:     state_nxt = RUN;
`ifdef CLOCK_MONITOR_STUCK_EN
            STUCK:   if (edge_det) state_nxt = SKIP;
`endif
            default: state_nxt = ACQ;
        endcase
`ifdef CLOCK_MONITOR_STUCK_EN
        if (to_hit && !edge_det && state != STUCK) state_nxt = STUCK;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            hi_len       <= '0;
            lo_len       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            err          <= 1'b0;
            have_hi      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (edge_det)          cnt <= CNT_W'(1);
            else if (cnt != CMAX)  cnt <= cnt + 1'b1;

            if (capture) begin
                if (level) begin
                    lo_len <= cnt;
                    if (state == RUN && have_hi) begin
                        period_valid <= 1'b1;
                        period       <= {1'b0, hi_len} + {1'b0, cnt};
                    end
                end else begin
                    hi_len  <= cnt;
                    have_hi <= 1'b1;
                end
            end
`ifdef CLOCK_MONITOR_STUCK_EN
            // A stall invalidates the last high phase for period pairing.
            if (state == STUCK) have_hi <= 1'b0;
`endif
            // A bad capture wins over a simultaneous clear.
            if (capture && bad) err <= 1'b1;
            else if (err_clr)   err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed self-checking bench for clock_monitor (default and CNT_W=4 instances).
// Stuck-input expectations follow CLOCK_MONITOR_STUCK_EN.
module tb_clock_monitor;

`ifdef CLOCK_MONITOR_STUCK_EN
    localparam logic EXP_STK = 1'b1;
    localparam int   EXP_PV1 = 0;
    localparam int   EXP_PV2 = 1;
`else
    localparam logic EXP_STK = 1'b0;
    localparam int   EXP_PV1 = 1;
    localparam int   EXP_PV2 = 2;
`endif

    logic        clk = 1'b0;
    logic        reset, mon_in, err_clr;
    logic [15:0] hi_len, lo_len;
    logic [16:0] period;
    logic        period_valid, err, stuck;
    logic        mon4, err_clr4;
    logic [3:0]  hi4, lo4;
    logic [4:0]  period4;
    logic        pv4, err4, stuck4;

    int n_chk = 0;
    int n_err = 0;
    int pv_cnt = 0;
    int base;

    always #5 clk = ~clk;

    clock_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .mon_in       (mon_in),
        .err_clr      (err_clr),
        .hi_len       (hi_len),
        .lo_len       (lo_len),
        .period       (period),
        .period_valid (period_valid),
        .err          (err),
        .stuck        (stuck)
    );

    clock_monitor #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .mon_in       (mon4),
        .err_clr      (err_clr4),
        .hi_len       (hi4),
        .lo_len       (lo4),
        .period       (period4),
        .period_valid (pv4),
        .err          (err4),
        .stuck        (stuck4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (period_valid) pv_cnt++;
        end
    endtask

    task automatic half(input logic v, input int n);
        mon_in = v;
        tick(n);
    endtask

    initial begin
        reset = 1'b1; mon_in = 1'b0; err_clr = 1'b0; mon4 = 1'b0; err_clr4 = 1'b0;
        tick(3);
        chk("rst_hi", hi_len, 0);
        chk("rst_lo", lo_len, 0);
        chk("rst_period", period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_stuck", stuck, 0);
        reset = 1'b0;
        tick(2);

        // 5/5 toggling: first pulse only after ACQ and SKIP
        base = pv_cnt;
        repeat (3) begin half(1, 5); half(0, 5); end
        chk("pv_warmup", pv_cnt - base, 2);
        base = pv_cnt;
        repeat (5) begin half(1, 5); half(0, 5); end
        chk("pv_per_10", pv_cnt - base, 5);
        chk("good_hi", hi_len, 5);
        chk("good_lo", lo_len, 5);
        chk("good_period", period, 10);
        chk("good_err", err, 0);

        // 8-cycle high phase sets err, sticky until cleared
        half(1, 8);
        half(0, 2);
        chk("err_before_cap", err, 0);
        tick(1);
        chk("long_hi", hi_len, 8);
        chk("long_err", err, 1);
        tick(2);
        half(1, 5); half(0, 5);
        chk("err_sticky", err, 1);
        chk("hi_back_5", hi_len, 5);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("err_cleared", err, 0);
        half(1, 8);
        chk("lo_6_ok", lo_len, 6);
        chk("err_lo6", err, 0);
        half(0, 3);
        chk("err_reset", err, 1);
        chk("long_hi2", hi_len, 8);

        // err_clr coinciding with an out-of-range capture
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("err_clr2", err, 0);
        tick(4);
        mon_in = 1'b1; tick(2);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("clr_vs_set", err, 1);
        chk("lo_8", lo_len, 8);
        tick(1);
        half(0, 5);

        // reset in the middle of a high phase after 20 good periods
        base = pv_cnt;
        repeat (20) begin half(1, 5); half(0, 5); end
        chk("pv_20", pv_cnt - base, 20);
        chk("err_pre_rst", err, 1);
        half(1, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_hi", hi_len, 0);
        chk("mid_rst_lo", lo_len, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_pv", period_valid, 0);
        chk("mid_rst_stuck", stuck, 0);
        tick(2);
        reset = 1'b0;
        base = pv_cnt;
        tick(5);
        half(0, 5);
        chk("no_pv_in_skip", pv_cnt - base, 0);
        half(1, 5);
        chk("pv_after_reacq", pv_cnt - base, 1);
        chk("reacq_hi", hi_len, 5);
        chk("reacq_lo", lo_len, 5);
        chk("reacq_period", period, 10);
        chk("reacq_err", err, 0);

        // input held low for 70 cycles
        base = pv_cnt;
        half(0, 60);
        chk("stuck_early", stuck, 0);
        tick(10);
        chk("stuck_set", stuck, EXP_STK);
        half(1, 5);
        chk("stuck_clr1", stuck, 0);
        chk("stuck_pv1", pv_cnt - base, EXP_PV1);
        half(0, 5);
        chk("stuck_clr2", stuck, 0);
        chk("stuck_pv2", pv_cnt - base, EXP_PV1);
        half(1, 5);
        chk("stuck_pv3", pv_cnt - base, EXP_PV2);

        // CNT_W=4: high phase longer than the counter range saturates
        mon4 = 1'b1; tick(5);
        mon4 = 1'b0; tick(5);
        mon4 = 1'b1; tick(3);
        chk("w4_lo", lo4, 5);
        chk("w4_err_ok", err4, 0);
        tick(17);
        mon4 = 1'b0; tick(3);
        chk("w4_hi_sat", hi4, 15);
        chk("w4_err", err4, 1);
        chk("w4_stuck", stuck4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
